mcb_port_ram: RTL and testbench
===============================

Name: mcb_port_ram

Overview:
- Single-clock, BRAM-backed stand-in for one Xilinx MCB user port (cmd/wr/rd FIFO interface).
- Connects directly to the MCB-side ports of wb_mcb_8 (and other MCB-port masters), so the memory path can run without the DDR controller, in simulation and on boards without DRAM.
- Executes read and write burst commands against an internal word-addressed RAM.
- Presents MCB-style FIFO flags and counts to the master.

Parameters:
ADDR_WIDTH, 10, RAM word-address bits (RAM holds 2^ADDR_WIDTH 32-bit words).
CMD_FIFO_DEPTH, 4, command FIFO entries (power of two).
DATA_FIFO_DEPTH, 64, write and read data FIFO entries each (power of two, max 64).

Ports:
clk  input  1  clock; the master's mcb_*_clk outputs are driven from this same clock
rst_n  input  1  asynchronous active-low reset
mcb_cmd_en  input  1  push command
mcb_cmd_instr  input  3  000/010 write, 001/011 read, other ignored
mcb_cmd_bl  input  6  burst length minus 1 (1..64 words)
mcb_cmd_byte_addr  input  32  byte address
mcb_cmd_empty  output  1  command FIFO empty
mcb_cmd_full  output  1  command FIFO full
mcb_wr_en  input  1  push write word
mcb_wr_mask  input  4  per-byte mask, 1 = do not write byte
mcb_wr_data  input  32  write word
mcb_wr_empty  output  1  write FIFO empty
mcb_wr_full  output  1  write FIFO full
mcb_wr_underrun  output  1  head write command stalled for data
mcb_wr_count  output  7  write FIFO occupancy
mcb_wr_error  output  1  sticky: push while full
mcb_rd_en  input  1  pop read word
mcb_rd_data  output  32  read FIFO head (first-word-fall-through)
mcb_rd_empty  output  1  read FIFO empty
mcb_rd_full  output  1  read FIFO full
mcb_rd_overflow  output  1  held 0 (overflow prevented by reservation)
mcb_rd_count  output  7  read FIFO occupancy
mcb_rd_error  output  1  sticky: pop while empty

Behaviour:
- Reset values: all FIFOs empty; cmd_empty = wr_empty = rd_empty = 1; all other outputs 0; engine in IDLE. RAM contents are not cleared.
- Reset asserted mid-burst aborts the burst immediately; partially written words remain in RAM.
- Flags and counts are registered and reflect occupancy after the current edge.
- Command FIFO:
  - cmd_en with !cmd_full pushes {instr, bl, addr}.
  - cmd_en while full is dropped silently.
- Write FIFO:
  - wr_en with !wr_full pushes {mask, data}.
  - wr_en while wr_full is dropped and sets wr_error. A simultaneous engine pop does not rescue it.
- Read FIFO:
  - rd_en with !rd_empty pops.
  - rd_en while empty is ignored and sets rd_error.
  - wr_error and rd_error clear only on reset.
- Word index = byte_addr[ADDR_WIDTH+1:2]. Byte-address bits [1:0] and bits above the index are ignored.
- Burst words use index+0 .. index+bl, wrapping modulo 2^ADDR_WIDTH.
- Engine FSM (IDLE, WRITE, READ, DRAIN):
  - IDLE, head is an ignored instr: pop and discard (1 cycle).
  - IDLE, head is a write: if wr_count >= bl+1, pop to WRITE; else stay in IDLE with wr_underrun = 1.
  - IDLE, head is a read: if free read slots (DATA_FIFO_DEPTH - rd_count - in-flight) >= bl+1, reserve them and pop to READ; else wait.
  - WRITE: each cycle pop one write-FIFO word and write RAM bytes whose mask bit is 0. After bl+1 words, go to IDLE.
  - READ: each cycle present one RAM address. Data is registered one cycle later and pushed to the read FIFO. After the last address, go to DRAIN (1 cycle), then IDLE.
  - One command in flight at a time; commands execute in order.
- Latency:
  - cmd_en at edge E0 → pop at E1 → first RAM access at E2.
  - Read: first word pushed at E3; rd_empty low after E3. Subsequent words arrive one per cycle.
  - Write: data is in RAM after edge E2+k for word k.
- A read of an address written by an earlier command returns the new data, because commands are serialized.

Test Plan:
- Push 4 write words 0x11223344.., mask 0, then write cmd bl=3 addr 0x100; then read cmd bl=3 addr 0x100 → rd_count reaches 4; words pop back identical in order; rd_empty falls 3 edges after the read cmd_en.
- Write 0xAABBCCDD to addr 0x40 (mask 0), then 0x00000000 with mask 0b0101 → read of 0x40 returns 0x00BB00DD.
- Write cmd bl=7 with only 2 words queued → wr_underrun = 1 and no RAM change; push 6 more words → underrun drops, burst completes, readback matches.
- Push 65 write words with no command → wr_full after 64, wr_count = 64, wr_error = 1; rd_en on empty → rd_error = 1.
- Read cmd bl=63 at word address 2^ADDR_WIDTH-2 → indices wrap to 0; instr 100 (refresh) is discarded without effect; a 5th cmd_en with 4 queued is dropped.
- rst_n low during a 64-word read → all flags return to reset values asynchronously; earlier-written RAM data still reads back correctly after reset.

Source files
------------

// File: rtl/mcb_port_if.sv
// MCB user-port bundle: command, write-data and read-data FIFO signals.
// Signal names match the MCB port names so existing masters map one-to-one.
interface mcb_port_if;
    logic        mcb_cmd_en;
    logic [2:0]  mcb_cmd_instr;
    logic [5:0]  mcb_cmd_bl;
    logic [31:0] mcb_cmd_byte_addr;
    logic        mcb_cmd_empty;
    logic        mcb_cmd_full;
    logic        mcb_wr_en;
    logic [3:0]  mcb_wr_mask;
    logic [31:0] mcb_wr_data;
    logic        mcb_wr_empty;
    logic        mcb_wr_full;
    logic        mcb_wr_underrun;
    logic [6:0]  mcb_wr_count;
    logic        mcb_wr_error;
    logic        mcb_rd_en;
    logic [31:0] mcb_rd_data;
    logic        mcb_rd_empty;
    logic        mcb_rd_full;
    logic        mcb_rd_overflow;
    logic [6:0]  mcb_rd_count;
    logic        mcb_rd_error;

    modport master (
        output mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
        output mcb_wr_en, mcb_wr_mask, mcb_wr_data, mcb_rd_en,
        input  mcb_cmd_empty, mcb_cmd_full,
        input  mcb_wr_empty, mcb_wr_full, mcb_wr_underrun, mcb_wr_count, mcb_wr_error,
        input  mcb_rd_data, mcb_rd_empty, mcb_rd_full, mcb_rd_overflow, mcb_rd_count, mcb_rd_error
    );

    modport slave (
        input  mcb_cmd_en, mcb_cmd_instr, mcb_cmd_bl, mcb_cmd_byte_addr,
        input  mcb_wr_en, mcb_wr_mask, mcb_wr_data, mcb_rd_en,
        output mcb_cmd_empty, mcb_cmd_full,
        output mcb_wr_empty, mcb_wr_full, mcb_wr_underrun, mcb_wr_count, mcb_wr_error,
        output mcb_rd_data, mcb_rd_empty, mcb_rd_full, mcb_rd_overflow, mcb_rd_count, mcb_rd_error
    );
endinterface

// File: rtl/mcb_port_ram.sv
// BRAM-backed stand-in for one MCB user port: cmd/wr/rd FIFOs plus a
// single-command burst engine over a word-addressed 32-bit RAM.
module mcb_port_ram #(
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned CMD_FIFO_DEPTH  = 4,
    parameter int unsigned DATA_FIFO_DEPTH = 64
) (
    input  logic     clk,
    input  logic     rst_n,
    mcb_port_if.slave mcb
);
    localparam int unsigned CPW = $clog2(CMD_FIFO_DEPTH);
    localparam int unsigned DPW = $clog2(DATA_FIFO_DEPTH);
    localparam logic [CPW:0] CMD_DEPTH  = (CPW+1)'(CMD_FIFO_DEPTH);
    localparam logic [6:0]   DATA_DEPTH = 7'(DATA_FIFO_DEPTH);
    localparam int unsigned  RAM_WORDS  = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [2:0]            instr;
        logic [5:0]            bl;
        logic [ADDR_WIDTH-1:0] idx;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    // ---------------- command FIFO ----------------
    cmd_t           cmd_mem [CMD_FIFO_DEPTH];
    logic [CPW-1:0] cmd_wp, cmd_rp;
    logic [CPW:0]   cmd_cnt;
    logic           cmd_full, cmd_empty, cmd_push, cmd_pop;
    cmd_t           head;

    assign cmd_full  = (cmd_cnt == CMD_DEPTH);
    assign cmd_empty = (cmd_cnt == '0);
    assign cmd_push  = mcb.mcb_cmd_en && !cmd_full;
    assign head      = cmd_mem[cmd_rp];

    always_ff @(posedge clk) begin
        if (cmd_push)
            cmd_mem[cmd_wp] <= '{instr: mcb.mcb_cmd_instr, bl: mcb.mcb_cmd_bl,
                                 idx: mcb.mcb_cmd_byte_addr[ADDR_WIDTH+1:2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wp <= cmd_wp + CPW'(1);
            if (cmd_pop)  cmd_rp <= cmd_rp + CPW'(1);
            cmd_cnt <= cmd_cnt + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
        end
    end

    // ---------------- write data FIFO ----------------
    logic [35:0]    wr_mem [DATA_FIFO_DEPTH];
    logic [DPW-1:0] wr_wp, wr_rp;
    logic [6:0]     wr_cnt;
    logic           wr_full, wr_push, wr_pop, wr_err;
    logic [3:0]     wr_head_mask;
    logic [31:0]    wr_head_data;

    assign wr_full = (wr_cnt == DATA_DEPTH);
    assign wr_push = mcb.mcb_wr_en && !wr_full;
    assign {wr_head_mask, wr_head_data} = wr_mem[wr_rp];

    always_ff @(posedge clk) begin
        if (wr_push) wr_mem[wr_wp] <= {mcb.mcb_wr_mask, mcb.mcb_wr_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_wp  <= '0;
            wr_rp  <= '0;
            wr_cnt <= '0;
            wr_err <= 1'b0;
        end else begin
            if (wr_push) wr_wp <= wr_wp + DPW'(1);
            if (wr_pop)  wr_rp <= wr_rp + DPW'(1);
            wr_cnt <= wr_cnt + 7'(wr_push) - 7'(wr_pop);
            if (mcb.mcb_wr_en && wr_full) wr_err <= 1'b1;
        end
    end

    // ---------------- read data FIFO (first-word-fall-through) ----------------
    logic [31:0]    rd_mem [DATA_FIFO_DEPTH];
    logic [DPW-1:0] rd_wp, rd_rp;
    logic [6:0]     rd_cnt;
    logic           rd_empty, rd_push, rd_pop, rd_err;
    logic [31:0]    rdata_q;
    logic           rvalid_q;

    assign rd_empty = (rd_cnt == '0);
    assign rd_pop   = mcb.mcb_rd_en && !rd_empty;
    assign rd_push  = rvalid_q;

    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_wp] <= rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_wp  <= '0;
            rd_rp  <= '0;
            rd_cnt <= '0;
            rd_err <= 1'b0;
        end else begin
            if (rd_push) rd_wp <= rd_wp + DPW'(1);
            if (rd_pop)  rd_rp <= rd_rp + DPW'(1);
            rd_cnt <= rd_cnt + 7'(rd_push) - 7'(rd_pop);
            if (mcb.mcb_rd_en && rd_empty) rd_err <= 1'b1;
        end
    end

    // ---------------- burst engine ----------------
    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [5:0]            left_q;
    logic [6:0]            rsv_q;
    logic                  load, reserve, ram_we, ram_re, underrun;
    logic                  head_wr, head_rd;
    logic [6:0]            need, free_slots;

    assign head_wr    = (head.instr == 3'b000) || (head.instr == 3'b010);
    assign head_rd    = (head.instr == 3'b001) || (head.instr == 3'b011);
    assign need       = {1'b0, head.bl} + 7'd1;
    // Read slots already promised to the running burst count as occupied, so the FIFO never overflows.
    assign free_slots = DATA_DEPTH - rd_cnt - rsv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cmd_pop  = 1'b0;
        wr_pop   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        load     = 1'b0;
        reserve  = 1'b0;
        underrun = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cmd_empty) begin
                    if (head_wr) begin
                        if (wr_cnt >= need) begin
                            cmd_pop = 1'b1;
                            load    = 1'b1;
                            state_n = WRITE;
                        end else begin
                            underrun = 1'b1;
                        end
                    end else if (head_rd) begin
                        if (free_slots >= need) begin
                            cmd_pop = 1'b1;
                            load    = 1'b1;
                            reserve = 1'b1;
                            state_n = READ;
                        end
                    end else begin
                        cmd_pop = 1'b1;
                    end
                end
            end
            WRITE: begin
                wr_pop = 1'b1;
                ram_we = 1'b1;
                if (left_q == '0) state_n = IDLE;
            end
            READ: begin
                ram_re = 1'b1;
                if (left_q == '0) state_n = DRAIN;
            end
            DRAIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            left_q   <= '0;
            rsv_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (load) begin
                addr_q <= head.idx;
                left_q <= head.bl;
            end else if (ram_we || ram_re) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                left_q <= left_q - 6'd1;
            end
            rsv_q    <= rsv_q + (reserve ? need : 7'd0) - 7'(rd_push);
            rvalid_q <= ram_re;
        end
    end

    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!wr_head_mask[b]) ram[addr_q][8*b +: 8] <= wr_head_data[8*b +: 8];
            end
        end
        if (ram_re) rdata_q <= ram[addr_q];
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mcb.mcb_cmd_byte_addr[31:ADDR_WIDTH+2], mcb.mcb_cmd_byte_addr[1:0]};

    assign mcb.mcb_cmd_empty   = cmd_empty;
    assign mcb.mcb_cmd_full    = cmd_full;
    assign mcb.mcb_wr_empty    = (wr_cnt == '0);
    assign mcb.mcb_wr_full     = wr_full;
    assign mcb.mcb_wr_underrun = underrun;
    assign mcb.mcb_wr_count    = wr_cnt;
    assign mcb.mcb_wr_error    = wr_err;
    assign mcb.mcb_rd_data     = rd_mem[rd_rp];
    assign mcb.mcb_rd_empty    = rd_empty;
    assign mcb.mcb_rd_full     = (rd_cnt == DATA_DEPTH);
    assign mcb.mcb_rd_overflow = 1'b0;
    assign mcb.mcb_rd_count    = rd_cnt;
    assign mcb.mcb_rd_error    = rd_err;
endmodule

// File: tb/tb_mcb_port_ram.sv
// Directed bench for mcb_port_ram: bursts, masks, underrun, FIFO limits,
// address wrap, command dropping and asynchronous reset.
module tb_mcb_port_ram;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mcb_port_if bus();

    mcb_port_ram #(
        .ADDR_WIDTH(10),
        .CMD_FIFO_DEPTH(4),
        .DATA_FIFO_DEPTH(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mcb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: each starts and ends at a falling edge.
    task automatic push_wr(input logic [3:0] mask, input logic [31:0] data);
        bus.mcb_wr_en   = 1'b1;
        bus.mcb_wr_mask = mask;
        bus.mcb_wr_data = data;
        @(negedge clk);
        bus.mcb_wr_en   = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [31:0] addr);
        bus.mcb_cmd_en        = 1'b1;
        bus.mcb_cmd_instr     = instr;
        bus.mcb_cmd_bl        = bl;
        bus.mcb_cmd_byte_addr = addr;
        @(negedge clk);
        bus.mcb_cmd_en        = 1'b0;
    endtask

    task automatic pop_word(output logic [31:0] d);
        d = bus.mcb_rd_data;
        bus.mcb_rd_en = 1'b1;
        @(negedge clk);
        bus.mcb_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (int'(bus.mcb_rd_count) >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        total++;
        if ({bus.mcb_cmd_empty, bus.mcb_wr_empty, bus.mcb_rd_empty} !== 3'b111) begin
            bad++;
            $display("FAIL reset_empty_flags got=%b want=111",
                     {bus.mcb_cmd_empty, bus.mcb_wr_empty, bus.mcb_rd_empty});
        end
        total++;
        if ({bus.mcb_cmd_full, bus.mcb_wr_full, bus.mcb_rd_full, bus.mcb_wr_underrun,
             bus.mcb_wr_error, bus.mcb_rd_error, bus.mcb_rd_overflow,
             bus.mcb_wr_count, bus.mcb_rd_count} !== 21'd0) begin
            bad++;
            $display("FAIL reset_other_outputs got=%h want=0",
                     {bus.mcb_cmd_full, bus.mcb_wr_full, bus.mcb_rd_full, bus.mcb_wr_underrun,
                      bus.mcb_wr_error, bus.mcb_rd_error, bus.mcb_rd_overflow,
                      bus.mcb_wr_count, bus.mcb_rd_count});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_burst;
        logic [31:0] exp [4];
        logic [31:0] d;
        bit ok;
        exp[0] = 32'h11223344; exp[1] = 32'h55667788; exp[2] = 32'h99AABBCC; exp[3] = 32'hDDEEFF00;
        for (int i = 0; i < 4; i++) push_wr(4'b0000, exp[i]);
        push_cmd(3'b000, 6'd3, 32'h100);
        idle(10);
        push_cmd(3'b001, 6'd3, 32'h100);   // edge E0 has passed
        idle(2);                            // after E2
        total++;
        if (bus.mcb_rd_empty !== 1'b1) begin
            bad++;
            $display("FAIL burst_rd_empty_E2 got=%b want=1", bus.mcb_rd_empty);
        end
        idle(1);                            // after E3
        total++;
        if (bus.mcb_rd_empty !== 1'b0) begin
            bad++;
            $display("FAIL burst_rd_empty_E3 got=%b want=0", bus.mcb_rd_empty);
        end
        wait_rd(4, ok);
        total++;
        if (!ok || bus.mcb_rd_count !== 7'd4) begin
            bad++;
            $display("FAIL burst_rd_count got=%0d want=4", bus.mcb_rd_count);
        end
        for (int i = 0; i < 4; i++) begin
            pop_word(d);
            total++;
            if (d !== exp[i]) begin
                bad++;
                $display("FAIL burst_data[%0d] got=%h want=%h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_mask;
        logic [31:0] d;
        bit ok;
        push_wr(4'b0000, 32'hAABBCCDD);
        push_cmd(3'b000, 6'd0, 32'h40);
        push_wr(4'b0101, 32'h00000000);
        push_cmd(3'b010, 6'd0, 32'h40);
        push_cmd(3'b011, 6'd0, 32'h40);
        wait_rd(1, ok);
        pop_word(d);
        total++;
        if (!ok || d !== 32'h00BB00DD) begin
            bad++;
            $display("FAIL mask_merge got=%h want=00bb00dd", d);
        end
    endtask

    task automatic test_underrun;
        logic [31:0] d;
        bit ok;
        push_wr(4'b0000, 32'h5A000000);
        push_wr(4'b0000, 32'h5A000001);
        push_cmd(3'b000, 6'd7, 32'h200);
        idle(4);
        total++;
        if ({bus.mcb_wr_underrun, bus.mcb_wr_count, bus.mcb_cmd_empty} !== {1'b1, 7'd2, 1'b0}) begin
            bad++;
            $display("FAIL underrun_stall got=%b/%0d/%b want=1/2/0",
                     bus.mcb_wr_underrun, bus.mcb_wr_count, bus.mcb_cmd_empty);
        end
        for (int i = 2; i < 8; i++) push_wr(4'b0000, 32'h5A000000 + 32'(i));
        idle(12);
        total++;
        if ({bus.mcb_wr_underrun, bus.mcb_wr_count, bus.mcb_cmd_empty} !== {1'b0, 7'd0, 1'b1}) begin
            bad++;
            $display("FAIL underrun_release got=%b/%0d/%b want=0/0/1",
                     bus.mcb_wr_underrun, bus.mcb_wr_count, bus.mcb_cmd_empty);
        end
        push_cmd(3'b001, 6'd7, 32'h200);
        wait_rd(8, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL underrun_read_timeout got=%0d want=8", bus.mcb_rd_count);
        end
        for (int i = 0; i < 8; i++) begin
            pop_word(d);
            total++;
            if (d !== 32'h5A000000 + 32'(i)) begin
                bad++;
                $display("FAIL underrun_data[%0d] got=%h want=%h", i, d, 32'h5A000000 + 32'(i));
            end
        end
    endtask

    task automatic test_full_errors;
        for (int i = 0; i < 64; i++) push_wr(4'b0000, 32'hC0000000 + 32'(i));
        total++;
        if ({bus.mcb_wr_full, bus.mcb_wr_count, bus.mcb_wr_error} !== {1'b1, 7'd64, 1'b0}) begin
            bad++;
            $display("FAIL wr_full_at_64 got=%b/%0d/%b want=1/64/0",
                     bus.mcb_wr_full, bus.mcb_wr_count, bus.mcb_wr_error);
        end
        push_wr(4'b0000, 32'hDEADBEEF);
        total++;
        if ({bus.mcb_wr_error, bus.mcb_wr_count} !== {1'b1, 7'd64}) begin
            bad++;
            $display("FAIL wr_error_overflow got=%b/%0d want=1/64", bus.mcb_wr_error, bus.mcb_wr_count);
        end
        bus.mcb_rd_en = 1'b1;
        @(negedge clk);
        bus.mcb_rd_en = 1'b0;
        total++;
        if ({bus.mcb_rd_error, bus.mcb_rd_count} !== {1'b1, 7'd0}) begin
            bad++;
            $display("FAIL rd_error_underflow got=%b/%0d want=1/0", bus.mcb_rd_error, bus.mcb_rd_count);
        end
        // Drain the 64 queued words into the top two words of RAM, wrapping to index 0.
        push_cmd(3'b000, 6'd63, 32'hFF8);
        idle(70);
        total++;
        if ({bus.mcb_wr_empty, bus.mcb_wr_count} !== {1'b1, 7'd0}) begin
            bad++;
            $display("FAIL wr_drain got=%b/%0d want=1/0", bus.mcb_wr_empty, bus.mcb_wr_count);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        bit ok;
        int errs;
        push_cmd(3'b001, 6'd63, 32'hFF8);
        wait_rd(64, ok);
        total++;
        if (!ok || {bus.mcb_rd_full, bus.mcb_rd_count} !== {1'b1, 7'd64}) begin
            bad++;
            $display("FAIL wrap_rd_full got=%b/%0d want=1/64", bus.mcb_rd_full, bus.mcb_rd_count);
        end
        errs = 0;
        for (int i = 0; i < 64; i++) begin
            pop_word(d);
            total++;
            if (d !== 32'hC0000000 + 32'(i)) begin
                bad++;
                errs++;
                if (errs <= 4)
                    $display("FAIL wrap_data[%0d] got=%h want=%h", i, d, 32'hC0000000 + 32'(i));
            end
        end
        // Bits above the index and the byte offset are ignored: this is word 0.
        push_cmd(3'b001, 6'd0, 32'h00001003);
        wait_rd(1, ok);
        pop_word(d);
        total++;
        if (!ok || d !== 32'hC0000002) begin
            bad++;
            $display("FAIL wrap_index0 got=%h want=c0000002", d);
        end
    endtask

    task automatic test_cmd_queue;
        logic [31:0] d;
        bit ok;
        push_cmd(3'b100, 6'd5, 32'h0);
        idle(3);
        total++;
        if ({bus.mcb_cmd_empty, bus.mcb_wr_count, bus.mcb_rd_empty, bus.mcb_wr_underrun} !== {1'b1, 7'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL refresh_discard got=%b/%0d/%b/%b want=1/0/1/0",
                     bus.mcb_cmd_empty, bus.mcb_wr_count, bus.mcb_rd_empty, bus.mcb_wr_underrun);
        end
        for (int i = 0; i < 4; i++) push_cmd(3'b000, 6'd0, 32'h300 + 32'(4 * i));
        total++;
        if ({bus.mcb_cmd_full, bus.mcb_wr_underrun} !== 2'b11) begin
            bad++;
            $display("FAIL cmd_full got=%b want=11", {bus.mcb_cmd_full, bus.mcb_wr_underrun});
        end
        push_cmd(3'b000, 6'd0, 32'h310);
        for (int i = 0; i < 4; i++) push_wr(4'b0000, 32'h30000000 + 32'(i));
        idle(10);
        total++;
        if ({bus.mcb_cmd_empty, bus.mcb_wr_underrun} !== 2'b10) begin
            bad++;
            $display("FAIL cmd_fifth_dropped got=%b want=10", {bus.mcb_cmd_empty, bus.mcb_wr_underrun});
        end
        push_cmd(3'b001, 6'd3, 32'h300);
        wait_rd(4, ok);
        for (int i = 0; i < 4; i++) begin
            pop_word(d);
            total++;
            if (!ok || d !== 32'h30000000 + 32'(i)) begin
                bad++;
                $display("FAIL cmd_queue_data[%0d] got=%h want=%h", i, d, 32'h30000000 + 32'(i));
            end
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] d;
        bit ok;
        push_cmd(3'b001, 6'd63, 32'h200);
        idle(8);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.mcb_cmd_empty, bus.mcb_wr_empty, bus.mcb_rd_empty, bus.mcb_rd_count,
             bus.mcb_wr_error, bus.mcb_rd_error} !== {3'b111, 7'd0, 2'b00}) begin
            bad++;
            $display("FAIL async_reset_flags got=%b/%0d/%b want=111/0/00",
                     {bus.mcb_cmd_empty, bus.mcb_wr_empty, bus.mcb_rd_empty}, bus.mcb_rd_count,
                     {bus.mcb_wr_error, bus.mcb_rd_error});
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        total++;
        if (bus.mcb_rd_empty !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_no_resume got=%b want=1", bus.mcb_rd_empty);
        end
        push_cmd(3'b001, 6'd7, 32'h200);
        wait_rd(8, ok);
        for (int i = 0; i < 8; i++) begin
            pop_word(d);
            total++;
            if (!ok || d !== 32'h5A000000 + 32'(i)) begin
                bad++;
                $display("FAIL post_reset_data[%0d] got=%h want=%h", i, d, 32'h5A000000 + 32'(i));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.mcb_cmd_en        = 1'b0;
        bus.mcb_cmd_instr     = 3'b000;
        bus.mcb_cmd_bl        = 6'd0;
        bus.mcb_cmd_byte_addr = 32'd0;
        bus.mcb_wr_en         = 1'b0;
        bus.mcb_wr_mask       = 4'd0;
        bus.mcb_wr_data       = 32'd0;
        bus.mcb_rd_en         = 1'b0;
        rst_n                 = 1'b0;
        @(negedge clk);
        test_reset();
        test_burst();
        test_mask();
        test_underrun();
        test_full_errors();
        test_wrap();
        test_cmd_queue();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule
